second_chance_key_ctrl: RTL

- Initiator/controller for an array of NUM_CELLS CAM key cells in the second-chance key store.
- Accepts lookup/insert/delete requests and broadcasts the key to all cells.
- Drives the one-hot chip-select plus write/delete strobes into the cells and consumes their per-cell empty/hit vectors.
- Keeps per-slot reference bits and a clock hand; evicts by the second-chance policy when the store is full.

---
 rtl/second_chance_pkg.sv | 21 ++
 rtl/sc_prio_enc.sv | 23 ++
 rtl/second_chance_key_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/second_chance_pkg.sv
// Shared types for the second-chance key/value store controllers.
package second_chance_pkg;

  // Request opcodes as presented on req_op_i.
  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MATCH = 3'd1,
    SCAN  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/sc_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag.
module sc_prio_enc #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/second_chance_key_ctrl.sv
// Controller for an array of CAM key cells: lookup/insert/delete with
// second-chance (clock) eviction when every cell holds a valid key.
module second_chance_key_ctrl
  import second_chance_pkg::*;
#(
  parameter int KEY_WIDTH = 32,
  parameter int NUM_CELLS = 8,
  parameter int IDX_WIDTH = $clog2(NUM_CELLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_op_i,
  input  logic [KEY_WIDTH-1:0] req_key_i,
  output logic                 rsp_valid_o,
  output logic                 rsp_hit_o,
  output logic [IDX_WIDTH-1:0] rsp_idx_o,
  output logic                 rsp_evicted_o,
  output logic [KEY_WIDTH-1:0] cell_key_o,
  output logic [NUM_CELLS-1:0] cell_cs_o,
  output logic                 cell_we_o,
  output logic                 cell_del_o,
  input  logic [NUM_CELLS-1:0] cell_empty_i,
  input  logic [NUM_CELLS-1:0] cell_fits_read_i
);

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [NUM_CELLS-1:0]   ref_q, ref_d;
  logic [IDX_WIDTH-1:0]   hand_q, hand_d;
  logic [IDX_WIDTH-1:0]   target_q, target_d;
  logic                   hit_q, hit_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   evicted_q, evicted_d;

  logic                   hit_found;
  logic [IDX_WIDTH-1:0]   hit_idx;
  logic                   empty_found;
  logic [IDX_WIDTH-1:0]   empty_idx;
  logic                   in_write;

  sc_prio_enc #(.N(NUM_CELLS), .IW(IDX_WIDTH)) u_hit_enc (
    .vec_i   (cell_fits_read_i),
    .found_o (hit_found),
    .idx_o   (hit_idx)
  );

  sc_prio_enc #(.N(NUM_CELLS), .IW(IDX_WIDTH)) u_empty_enc (
    .vec_i   (cell_empty_i),
    .found_o (empty_found),
    .idx_o   (empty_idx)
  );

  // State and datapath registers; reset clears ref bits and parks the hand at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_LOOKUP;
      key_q     <= '0;
      ref_q     <= '0;
      hand_q    <= '0;
      target_q  <= '0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      evicted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      key_q     <= key_d;
      ref_q     <= ref_d;
      hand_q    <= hand_d;
      target_q  <= target_d;
      hit_q     <= hit_d;
      idx_q     <= idx_d;
      evicted_q <= evicted_d;
    end
  end

  // Next-state logic: match, clock-hand scan, single-cycle write, response.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    key_d     = key_q;
    ref_d     = ref_q;
    hand_d    = hand_q;
    target_d  = target_q;
    hit_d     = hit_q;
    idx_d     = idx_q;
    evicted_d = evicted_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          op_d      = op_e'(req_op_i);
          key_d     = req_key_i;
          hit_d     = 1'b0;
          idx_d     = '0;
          evicted_d = 1'b0;
          state_d   = MATCH;
        end
      end
      MATCH: begin
        unique case (op_q)
          OP_LOOKUP: begin
            if (hit_found) begin
              hit_d          = 1'b1;
              idx_d          = hit_idx;
              ref_d[hit_idx] = 1'b1;
            end
            state_d = RESP;
          end
          OP_INSERT: begin
            if (hit_found) begin
              hit_d          = 1'b1;
              idx_d          = hit_idx;
              ref_d[hit_idx] = 1'b1;
              state_d        = RESP;
            end else if (empty_found) begin
              // A free cell always beats eviction; the hand stays put.
              target_d = empty_idx;
              idx_d    = empty_idx;
              state_d  = WRITE;
            end else begin
              state_d = SCAN;
            end
          end
          OP_DELETE: begin
            if (hit_found) begin
              hit_d    = 1'b1;
              idx_d    = hit_idx;
              target_d = hit_idx;
              state_d  = WRITE;
            end else begin
              state_d = RESP;
            end
          end
          default: state_d = RESP;
        endcase
      end
      SCAN: begin
        // Referenced slots get a second chance; the first unreferenced one is the victim.
        hand_d = hand_q + 1'b1;
        if (ref_q[hand_q]) begin
          ref_d[hand_q] = 1'b0;
        end else begin
          target_d  = hand_q;
          idx_d     = hand_q;
          evicted_d = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        ref_d[target_q] = 1'b0;
        state_d         = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_write    = (state_q == WRITE) && !reset;
  assign req_ready_o = (state_q == IDLE) && !reset;
  assign rsp_valid_o = (state_q == RESP) && !reset;

  assign rsp_hit_o     = rsp_valid_o && hit_q;
  assign rsp_idx_o     = rsp_valid_o ? idx_q : '0;
  assign rsp_evicted_o = rsp_valid_o && evicted_q;

  assign cell_key_o = key_q;
  assign cell_we_o  = in_write && (op_q == OP_INSERT);
  assign cell_del_o = in_write && (op_q == OP_DELETE);

  // One-hot select of the target cell, only while writing.
  for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cs
    assign cell_cs_o[gi] = in_write && (target_q == IDX_WIDTH'(gi));
  end

endmodule
